// File: rtl/ahb_apb_bridge_pkg.sv
// Shared definitions for the AHB-Lite to APB bridge: FSM state type and AHB code points.
// ERR1/ERR2 states exist only when AHB_APB_BRIDGE_SLVERR_EN is defined.
package ahb_apb_bridge_pkg;

`ifdef AHB_APB_BRIDGE_SLVERR_EN
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;
`endif

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_apb_pstrb_gen.sv
// Combinational APB write-strobe generator from registered HSIZE, HADDR[1:0] and HWRITE.
module ahb_apb_pstrb_gen
  import ahb_apb_bridge_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  input  logic       hwrite,
  output logic [3:0] pstrb
);

  always_comb begin
    pstrb = '0;
    if (hwrite) begin
      case (hsize)
        HSIZE_BYTE: pstrb = 4'b0001 << addr_lo;
        HSIZE_HALF: pstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
        // Word, and oversized sizes when they are executed rather than rejected.
        default:    pstrb = '1;
      endcase
    end
  end

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge; one APB SETUP/ACCESS per accepted AHB beat.
// Optional macro AHB_APB_BRIDGE_SLVERR_EN enables the two-cycle ERROR response.
module ahb_apb_bridge
  import ahb_apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic                    HWRITE,
  input  logic                    HMASTLOCK,
  input  logic                    HREADY,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [2:0]              PPROT,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  state_t                  state_q, state_d, start_state;
  logic                    take;
  logic                    hreadyout, hresp, psel, penable;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [2:0]              size_q;
  logic [2:0]              pprot_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH-1:0]   hrdata_q;
  logic                    unused_ok;

  // Accepting only while our own HREADYOUT is high keeps a held address phase from being taken early.
  assign take = HSEL & HREADY & is_active(HTRANS) & hreadyout;

`ifdef AHB_APB_BRIDGE_SLVERR_EN
  assign start_state = (HSIZE > HSIZE_WORD) ? ST_ERR1 : ST_SETUP;
  assign unused_ok   = ^{HBURST, HMASTLOCK, HPROT[3:2]};
`else
  assign start_state = ST_SETUP;
  assign unused_ok   = ^{HBURST, HMASTLOCK, HPROT[3:2], PSLVERR};
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (take) state_d = start_state;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
`ifdef AHB_APB_BRIDGE_SLVERR_EN
          if (PSLVERR) state_d = ST_ERR1;
          else         state_d = take ? start_state : ST_IDLE;
`else
          state_d = take ? start_state : ST_IDLE;
`endif
        end
      end
`ifdef AHB_APB_BRIDGE_SLVERR_EN
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = take ? start_state : ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      ST_SETUP: begin
        psel      = 1'b1;
        hreadyout = 1'b0;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
`ifdef AHB_APB_BRIDGE_SLVERR_EN
        hreadyout = PREADY & ~PSLVERR;
`else
        hreadyout = PREADY;
`endif
      end
`ifdef AHB_APB_BRIDGE_SLVERR_EN
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
      end
      ST_ERR2: hresp = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      pprot_q  <= '0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (take) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
        pprot_q <= {~HPROT[0], 1'b0, HPROT[1]};
      end
      if (state_q == ST_SETUP)  pwdata_q <= HWDATA;
      if (state_q == ST_ACCESS) hrdata_q <= PRDATA;
    end
  end

  ahb_apb_pstrb_gen u_pstrb_gen (
    .hsize   (size_q),
    .addr_lo (addr_q[1:0]),
    .hwrite  (write_q),
    .pstrb   (PSTRB)
  );

  assign PSEL      = psel;
  assign PENABLE   = penable;
  assign HREADYOUT = hreadyout;
  assign HRESP     = hresp;
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PPROT     = pprot_q;
  // Write data arrives in the AHB data phase, which coincides with SETUP.
  assign PWDATA    = (state_q == ST_SETUP)  ? HWDATA : pwdata_q;
  assign HRDATA    = (state_q == ST_ACCESS) ? PRDATA : hrdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge; HREADY is looped back from HREADYOUT.
module tb_ahb_apb_bridge;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0, HWRITE = 1'b0, HMASTLOCK = 1'b0;
  logic        HREADY;
  logic [15:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [2:0]  HSIZE = 3'b010, HBURST = '0;
  logic [3:0]  HPROT = 4'b0011;
  logic [1:0]  HTRANS = 2'b00;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP, PSEL, PENABLE, PWRITE;
  logic [2:0]  PPROT;
  logic [3:0]  PSTRB;
  logic [15:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b1, PSLVERR = 1'b0;

  int unsigned n_pass = 0, n_fail = 0, n_total = 0;

  ahb_apb_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PPROT(PPROT), .PSTRB(PSTRB),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [15:0] a, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a; HSIZE = sz;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  initial begin
    // Reset values
    step(); step(); settle();
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_paddr", 32'(PADDR), 32'd0);
    chk("rst_pstrb", 32'(PSTRB), 32'd0);
    chk("rst_pprot", 32'(PPROT), 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    HRESET = 1'b0;
    step();

    // Word write 0x4002
    addr_phase(1'b1, 16'h4002, 3'b010); HPROT = 4'b0011; settle();
    chk("wr_pre_psel", 32'(PSEL), 32'd0);
    step();
    bus_idle(); HWDATA = 32'hABCDABCD; settle();
    chk("wr_setup_psel", 32'(PSEL), 32'd1);
    chk("wr_setup_penable", 32'(PENABLE), 32'd0);
    chk("wr_setup_hready", 32'(HREADYOUT), 32'd0);
    chk("wr_paddr", 32'(PADDR), 32'h4002);
    chk("wr_pwrite", 32'(PWRITE), 32'd1);
    chk("wr_pstrb", 32'(PSTRB), 32'hF);
    chk("wr_pprot", 32'(PPROT), 32'h1);
    chk("wr_setup_pwdata", PWDATA, 32'hABCDABCD);
    step();
    HWDATA = 32'h0; settle();
    chk("wr_access_penable", 32'(PENABLE), 32'd1);
    chk("wr_access_hready", 32'(HREADYOUT), 32'd1);
    chk("wr_access_pwdata_held", PWDATA, 32'hABCDABCD);
    step(); settle();
    chk("wr_done_psel", 32'(PSEL), 32'd0);

    // Word read 0x1379
    addr_phase(1'b0, 16'h1379, 3'b010); HPROT = 4'b0000;
    step();
    bus_idle(); PRDATA = 32'h12345678; settle();
    chk("rd_pstrb", 32'(PSTRB), 32'h0);
    chk("rd_pwrite", 32'(PWRITE), 32'd0);
    chk("rd_pprot", 32'(PPROT), 32'h4);
    chk("rd_paddr", 32'(PADDR), 32'h1379);
    step(); settle();
    chk("rd_access_hready", 32'(HREADYOUT), 32'd1);
    chk("rd_hrdata", HRDATA, 32'h12345678);
    step();
    PRDATA = 32'hDEAD0000; settle();
    chk("rd_hrdata_hold", HRDATA, 32'h12345678);
    HPROT = 4'b0011;

    // Back-to-back write 0x2000 / read 0x2004, then HSEL=0 on 0x2028, then write 0x2030
    addr_phase(1'b1, 16'h2000, 3'b010);
    step();
    HWDATA = 32'h11112222; addr_phase(1'b0, 16'h2004, 3'b010); settle();
    chk("b2b_a_setup_paddr", 32'(PADDR), 32'h2000);
    chk("b2b_a_setup_pwrite", 32'(PWRITE), 32'd1);
    step(); settle();
    chk("b2b_a_access_penable", 32'(PENABLE), 32'd1);
    chk("b2b_a_access_paddr", 32'(PADDR), 32'h2000);
    step();
    HSEL = 1'b0; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 16'h2028; PRDATA = 32'h55AA55AA; settle();
    chk("b2b_b_setup_psel", 32'(PSEL), 32'd1);
    chk("b2b_b_setup_penable", 32'(PENABLE), 32'd0);
    chk("b2b_b_setup_paddr", 32'(PADDR), 32'h2004);
    chk("b2b_b_setup_pwrite", 32'(PWRITE), 32'd0);
    step(); settle();
    chk("b2b_b_hready", 32'(HREADYOUT), 32'd1);
    chk("b2b_b_hrdata", HRDATA, 32'h55AA55AA);
    step();
    addr_phase(1'b1, 16'h2030, 3'b010); settle();
    chk("nosel_psel", 32'(PSEL), 32'd0);
    chk("nosel_paddr", 32'(PADDR), 32'h2004);
    step();
    bus_idle(); HWDATA = 32'hC0DEC0DE; settle();
    chk("c_setup_paddr", 32'(PADDR), 32'h2030);
    chk("c_setup_psel", 32'(PSEL), 32'd1);
    chk("c_setup_pwdata", PWDATA, 32'hC0DEC0DE);
    step(); settle();
    chk("c_access_penable", 32'(PENABLE), 32'd1);
    step();

    // Byte write 0x3501 with three PREADY-low ACCESS cycles
    addr_phase(1'b1, 16'h3501, 3'b000);
    step();
    bus_idle(); PREADY = 1'b0; HWDATA = 32'h0000EE00; settle();
    chk("byte_pstrb", 32'(PSTRB), 32'h2);
    chk("byte_wait0", 32'(HREADYOUT), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(); settle();
      chk($sformatf("byte_wait%0d", i), 32'(HREADYOUT), 32'd0);
      chk($sformatf("byte_penable%0d", i), 32'(PENABLE), 32'd1);
    end
    step();
    PREADY = 1'b1; settle();
    chk("byte_done_hready", 32'(HREADYOUT), 32'd1);
    chk("byte_pwdata", PWDATA, 32'h0000EE00);
    step();

    // Halfword write 0x0006, reset asserted during ACCESS
    addr_phase(1'b1, 16'h0006, 3'b001);
    step();
    bus_idle(); settle();
    chk("half_pstrb", 32'(PSTRB), 32'hC);
    step();
    PREADY = 1'b0; HRESET = 1'b1; settle();
    chk("rstmid_pre_psel", 32'(PSEL), 32'd1);
    step(); settle();
    chk("rstmid_psel", 32'(PSEL), 32'd0);
    chk("rstmid_penable", 32'(PENABLE), 32'd0);
    chk("rstmid_hready", 32'(HREADYOUT), 32'd1);
    chk("rstmid_paddr", 32'(PADDR), 32'h0);
    chk("rstmid_pstrb", 32'(PSTRB), 32'h0);
    HRESET = 1'b0; PREADY = 1'b1;
    step();

    // Slave error and oversized HSIZE
    addr_phase(1'b0, 16'h0100, 3'b010);
    step();
    bus_idle(); settle();
    chk("err_setup_hresp", 32'(HRESP), 32'd0);
    step();
    PSLVERR = 1'b1; settle();
`ifdef AHB_APB_BRIDGE_SLVERR_EN
    chk("err_access_hready", 32'(HREADYOUT), 32'd0);
    step();
    PSLVERR = 1'b0; settle();
    chk("err1_hresp", 32'(HRESP), 32'd1);
    chk("err1_hready", 32'(HREADYOUT), 32'd0);
    chk("err1_psel", 32'(PSEL), 32'd0);
    step(); settle();
    chk("err2_hresp", 32'(HRESP), 32'd1);
    chk("err2_hready", 32'(HREADYOUT), 32'd1);
    step(); settle();
    chk("err_after_hresp", 32'(HRESP), 32'd0);
    addr_phase(1'b1, 16'h0101, 3'b011);
    step();
    bus_idle(); settle();
    chk("big_psel", 32'(PSEL), 32'd0);
    chk("big_err1_hresp", 32'(HRESP), 32'd1);
    chk("big_err1_hready", 32'(HREADYOUT), 32'd0);
    step(); settle();
    chk("big_err2_hresp", 32'(HRESP), 32'd1);
    chk("big_err2_hready", 32'(HREADYOUT), 32'd1);
    step();
`else
    chk("noerr_access_hready", 32'(HREADYOUT), 32'd1);
    chk("noerr_access_hresp", 32'(HRESP), 32'd0);
    step();
    PSLVERR = 1'b0; settle();
    chk("noerr_idle_hresp", 32'(HRESP), 32'd0);
    addr_phase(1'b1, 16'h0101, 3'b011);
    step();
    bus_idle(); settle();
    chk("big_psel", 32'(PSEL), 32'd1);
    chk("big_pstrb", 32'(PSTRB), 32'hF);
    chk("big_hresp", 32'(HRESP), 32'd0);
    step(); settle();
    chk("big_access_hready", 32'(HREADYOUT), 32'd1);
    step();
`endif

    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

Single-clock AHB-Lite slave to APB master bridge that converts each selected AHB transfer into one APB SETUP/ACCESS sequence. It sits between the AHB interconnect and the APB peripheral bus. AHB wait states are inserted until the APB slave completes. APB runs on the AHB clock; there is no separate PCLK or PRESETn.

## Interface
- ADDR_WIDTH, 16: width of HADDR and PADDR.
- DATA_WIDTH, 32: width of the data buses. Only 32 is supported; PSTRB is DATA_WIDTH/8 bits.
- Clock and reset: one clock, HCLK. Reset is synchronous and active-high, port HRESET.
- HCLK  in  1  clock for both the AHB and APB sides.
- HRESET  in  1  synchronous reset, active-high.
- HSEL, HWRITE, HMASTLOCK, HREADY  in  1  AHB select, direction, lock, and bus ready.
- HADDR  in  ADDR_WIDTH  AHB address.
- HWDATA  in  DATA_WIDTH  AHB write data.
- HSIZE, HBURST  in  3  AHB transfer size and burst type.
- HPROT  in  4  AHB protection.
- HTRANS  in  2  AHB transfer type.
- HRDATA  out  DATA_WIDTH  AHB read data.
- HREADYOUT, HRESP  out  1  AHB ready and error response.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PPROT  out  3  APB protection.
- PSTRB  out  DATA_WIDTH/8  APB write strobes.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY, PSLVERR  in  1  APB ready and slave error.

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ) at a rising edge.
  - On accept, register HADDR, HWRITE, HSIZE and HPROT.
  - IDLE/BUSY or HSEL=0: OKAY response with zero wait states; nothing reaches APB.
- HBURST and HMASTLOCK are ignored; each beat is an independent APB transfer.
- FSM states: IDLE, SETUP, ACCESS, ERR1, ERR2.
  - IDLE → SETUP on accept.
  - SETUP → ACCESS always.
  - ACCESS → IDLE when PREADY=1, PSLVERR=0, no new accept.
  - ACCESS → SETUP when PREADY=1, PSLVERR=0, new accept.
  - ACCESS → ERR1 when PREADY=1, PSLVERR=1.
  - ACCESS → ACCESS when PREADY=0.
  - ERR1 → ERR2 always.
  - ERR2 → SETUP on accept, else IDLE.
- HSIZE > 3'b010 on accept: no APB access; go directly to ERR1.
- Outputs by state:
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
  - PSEL=0 and PENABLE=0 in all other states.
- PADDR and PWRITE come from registered values and stay stable across SETUP and ACCESS.
- PWDATA:
  - In SETUP, PWDATA = HWDATA (the data phase of the accepted write).
  - HWDATA is captured at the SETUP→ACCESS edge and held through ACCESS.
- PSTRB, writes only (0000 for reads), using registered HADDR[1:0]:
  - byte: 0001 << HADDR[1:0].
  - halfword: 0011 << (2·HADDR[1]).
  - word: 1111.
- PPROT mapping:
  - PPROT[0] = HPROT[1].
  - PPROT[1] = 0.
  - PPROT[2] = ~HPROT[0].
- HRDATA = PRDATA during ACCESS; otherwise HRDATA holds its last value.
- HREADYOUT:
  - 1 in IDLE and ERR2.
  - 0 in SETUP and ERR1.
  - In ACCESS, HREADYOUT = PREADY & ~PSLVERR.
- HRESP = 1 in ERR1 and ERR2 only.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, HRDATA, HRESP = 0; HREADYOUT = 1; state = IDLE.
- Reset asserted mid-transfer aborts it; outputs reach reset values at the next edge.
- Minimum latency: accept at edge N, SETUP in cycle N+1, ACCESS in cycle N+2, HREADYOUT=1 in cycle N+2. One AHB wait state.
- Each PREADY=0 cycle in ACCESS adds one wait state.
- The AHB master holds the next address phase while HREADYOUT=0. It is accepted on the edge that completes ACCESS, giving back-to-back APB transfers with no IDLE cycle.
- A write at the end of a sequence gets its HWDATA in the SETUP cycle.

## Configuration
- Macro AHB_APB_BRIDGE_SLVERR_EN.
- Defined: PSLVERR and oversized HSIZE produce the two-cycle ERROR response (ERR1/ERR2).
- Undefined:
  - PSLVERR is ignored.
  - ERR1/ERR2 are not compiled.
  - HRESP is tied 0.
  - Oversized HSIZE is executed as a word access.

## Structure
- Package ahb_apb_bridge_pkg holds:
  - the state enum;
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ);
  - HSIZE codes (BYTE, HALF, WORD).
- One sub-module: ahb_apb_pstrb_gen, a combinational HSIZE/HADDR[1:0]/HWRITE → PSTRB function.

## Test plan
- Word write, HADDR=0x4002, HWDATA=0xABCDABCD, PREADY=1 → SETUP then ACCESS with PADDR=0x4002, PWRITE=1, PSTRB=1111, PWDATA=0xABCDABCD; one wait state.
- Word read of 0x1379, PRDATA=0x12345678 → PSTRB=0000; HRDATA=0x12345678 while HREADYOUT=1.
- HSEL=0 on HADDR=0x2028 between two valid transfers → no PSEL for 0x2028; neighbours complete normally.
- Byte write to 0x3501 with PREADY low for 3 ACCESS cycles → PSTRB=0010; HREADYOUT low 4 cycles.
- PSLVERR=1 with PREADY=1 (macro defined) → HRESP=1 for 2 cycles, HREADYOUT 0 then 1.
- HRESET asserted during ACCESS → PSEL=0, HREADYOUT=1 at the next edge.
